mtime_timer: RTL and testbench
==============================

Name: mtime_timer

Overview:
- Memory-mapped RISC-V machine timer: 64-bit `mtime` counter and 64-bit `mtimecmp` compare register.
- Drives the level-sensitive `mtime_int` input of the trap unit, which feeds `mip.MTI`.
- Sits on the core's data bus beside the other peripherals.
- Increments `mtime` at a fixed tick rate derived from the core clock by an internal prescaler.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: byte base address of the register block.
- CLK_DIV, 100: core clock cycles per `mtime` tick. Legal range is ≥1; 1 means increment every cycle.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- rd_en  input  1  bus read strobe
- wr_en  input  1  bus write strobe
- addr  input  32  bus byte address
- wr_data  input  32  bus write data
- rd_data  output  32  bus read data, combinational
- access_fault  output  1  access hits the block range but is unmapped or misaligned, combinational
- mtime_int  output  1  timer interrupt, registered level

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-low (`rst_n`).
- Register map (word offsets from BASE_ADDR):
  - 0x0 MTIMEL: mtime[31:0], RW
  - 0x4 MTIMEH: mtime[63:32], RW
  - 0x8 MTIMECMPL: mtimecmp[31:0], RW
  - 0xC MTIMECMPH: mtimecmp[63:32], RW
- Block decode range is BASE_ADDR to BASE_ADDR+0xF.
  - Outside the range, the block ignores the access, rd_data=0 and access_fault=0.
  - In range with addr[1:0]≠0, access_fault=1 while rd_en|wr_en. Reads return 0 and writes are dropped.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, mtimeh_shadow=0, mtime_int=0. rd_data=0 and access_fault=0 while rst_n=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - `tick` is asserted in the cycle prescaler==CLK_DIV-1.
  - Runs freely; bus writes do not affect it.
- Increment: on `tick`, mtime <= mtime+1 with full 64-bit carry. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write vs increment in the same cycle (per half; write wins):
  - Write MTIMEL on a tick: low <= wr_data; high <= high+carry, where carry comes from the old low == 32'hFFFF_FFFF.
  - Write MTIMEH on a tick: high <= wr_data; low <= low+1, and the carry is discarded.
- Read:
  - rd_data is valid in the same cycle as rd_en.
  - Reading MTIMEL returns mtime[31:0] and latches mtime[63:32] into mtimeh_shadow at the clock edge.
  - Reading MTIMEH returns mtimeh_shadow, not live mtime.
  - Software must read L then H to get a tear-free 64-bit value.
  - MTIMECMPL/H read live values.
  - rd_en=0 → rd_data=0.
- Simultaneous rd_en and wr_en to the same register: read returns the pre-write value; the write lands at the edge.
- Interrupt:
  - mtime_int <= (mtime ≥ mtimecmp), unsigned 64-bit, evaluated on current register values every cycle.
  - Latency is 1 cycle after the condition becomes true or false.
  - Level only; there is no internal clear. Software clears it by raising mtimecmp or lowering mtime.
- mtimecmp is never modified by hardware.
- Reset asserted mid-operation returns every register to its reset value at the next edge. mtime_int falls the cycle after reset is sampled.

Test Plan:
- Reset, then idle 1000 cycles with CLK_DIV=100 → MTIMEL reads 10; mtime_int=0 throughout.
- Write MTIMEL=32'hFFFF_FFFF and MTIMEH=0, then wait one tick → MTIMEL reads 0, then MTIMEH reads 1.
- Write MTIMEL at a tick edge with old low=32'hFFFF_FFFF and wr_data=5 → low=5, high incremented by 1.
- Write mtimecmp={0,20} with mtime=0 and CLK_DIV=1 → mtime_int rises the cycle after mtime reaches 20.
- Then write MTIMECMPH=1 → mtime_int falls the following cycle.
- Read MTIMEL with high=7, write MTIMEH=9, then read MTIMEH → returns 7 (shadow); a second L→H read pair returns 9.
- Access BASE_ADDR+0x2 → access_fault=1, rd_data=0, no register changes.
- Access BASE_ADDR+0x10 → access_fault=0, rd_data=0.
- Reset asserted while mtime_int=1 → mtime_int=0 one cycle later; all registers read their reset values.

Source files
------------

// File: rtl/mtime_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp pair on the data bus with a
// free-running prescaler and a registered level interrupt.
module mtime_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          CLK_DIV   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        access_fault,
  output logic        mtime_int
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [31:0]   mtime_lo;
  logic [31:0]   mtime_hi;
  logic [31:0]   cmp_lo;
  logic [31:0]   cmp_hi;
  logic [31:0]   mtimeh_shadow;

  logic [31:0] offset;
  logic        in_range;
  logic        misaligned;
  logic        hit;
  logic [1:0]  sel;
  logic        rd_hit;
  logic        wr_hit;

  logic        tick;
  logic        carry;
  logic [31:0] lo_inc;
  logic [31:0] hi_inc;

  // Subtracting the base keeps the decode correct even for a non-16-aligned base.
  assign offset     = addr - BASE_ADDR;
  assign in_range   = (offset < 32'd16);
  assign misaligned = (addr[1:0] != 2'b00);
  assign hit        = rst_n & in_range & ~misaligned;
  assign sel        = offset[3:2];
  assign rd_hit     = hit & rd_en;
  assign wr_hit     = hit & wr_en;

  assign access_fault = rst_n & in_range & misaligned & (rd_en | wr_en);

  always_comb begin
    rd_data = 32'd0;
    if (rd_hit) begin
      case (sel)
        2'd0:    rd_data = mtime_lo;
        2'd1:    rd_data = mtimeh_shadow;
        2'd2:    rd_data = cmp_lo;
        default: rd_data = cmp_hi;
      endcase
    end
  end

  // Each half either takes the bus write or its incremented value, so a write
  // to one half still lets the other half advance on a tick.
  assign tick   = (prescaler == PRE_MAX);
  assign carry  = tick & (mtime_lo == 32'hFFFF_FFFF);
  assign lo_inc = mtime_lo + {31'd0, tick};
  assign hi_inc = mtime_hi + {31'd0, carry};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler     <= '0;
      mtime_lo      <= 32'd0;
      mtime_hi      <= 32'd0;
      cmp_lo        <= 32'hFFFF_FFFF;
      cmp_hi        <= 32'hFFFF_FFFF;
      mtimeh_shadow <= 32'd0;
      mtime_int     <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);

      mtime_lo <= (wr_hit && sel == 2'd0) ? wr_data : lo_inc;
      mtime_hi <= (wr_hit && sel == 2'd1) ? wr_data : hi_inc;

      if (wr_hit && sel == 2'd2) cmp_lo <= wr_data;
      if (wr_hit && sel == 2'd3) cmp_hi <= wr_data;

      // Reading the low word snapshots the high word for a tear-free pair.
      if (rd_hit && sel == 2'd0) mtimeh_shadow <= mtime_hi;

      mtime_int <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
    end
  end

endmodule

// File: tb/tb_mtime_timer.sv
// Directed bench for mtime_timer: one instance at CLK_DIV=100 (a) and one at
// CLK_DIV=1 (b) share the bus inputs.
module tb_mtime_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic        fault_a, fault_b;
  logic        int_a, int_b;

  int checks = 0;
  int errors = 0;
  int e = 0;   // edges since reset release; tick edges are those with e%100==99

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  mtime_timer #(.BASE_ADDR(BASE), .CLK_DIV(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_a), .access_fault(fault_a), .mtime_int(int_a)
  );

  mtime_timer #(.BASE_ADDR(BASE), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_b), .access_fault(fault_b), .mtime_int(int_b)
  );

  task automatic do_read(input logic [31:0] a, output logic [31:0] da,
                         output logic fa, output logic [31:0] db);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    da = rd_data_a; fa = fault_a; db = rd_data_b;
    @(posedge clk); #1;
    rd_en = 1'b0;
    $display("rd addr=%h data_a=%h fault_a=%0d data_b=%h", a, da, fa, db);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic fa);
    addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    fa = fault_a;
    @(posedge clk); #1;
    wr_en = 1'b0;
    $display("wr addr=%h data=%h fault_a=%0d", a, d, fa);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 200 && (e % 100) != p; i++) begin
      @(posedge clk); #1;
    end
    if ((e % 100) != p) begin
      errors++;
      $display("FAIL phase_timeout: phase %0d required %0d", e % 100, p);
    end
  endtask

  task automatic test_reset();
    logic [31:0] da, db;
    logic fa;
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = BASE; wr_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (int_a !== 1'b0) begin errors++; $display("FAIL reset_int: got %b required 0", int_a); end
    rd_en = 1'b1; addr = BASE + 32'h8;
    @(negedge clk);
    checks++; if (rd_data_a !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h required 0", rd_data_a); end
    @(posedge clk); #1;
    addr = BASE + 32'h2;
    @(negedge clk);
    checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b required 0", fault_a); end
    @(posedge clk); #1;
    rd_en = 1'b0; rst_n = 1'b1;
    do_read(BASE + 32'h8, da, fa, db);
    checks++; if (da !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmpl: got %h required ffffffff", da); end
    do_read(BASE + 32'hC, da, fa, db);
    checks++; if (da !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmph: got %h required ffffffff", da); end
  endtask

  task automatic test_idle();
    logic [31:0] da, db;
    logic fa;
    logic bad = 1'b0;
    for (int i = 0; i < 2000 && e < 1000; i++) begin
      @(posedge clk); #1;
      if (int_a !== 1'b0) bad = 1'b1;
    end
    if (e != 1000) begin errors++; $display("FAIL idle_timeout: edges %0d required 1000", e); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_int: got %b required 0", bad); end
    do_read(BASE, da, fa, db);
    checks++; if (da !== 32'd10) begin errors++; $display("FAIL idle_mtimel: got %h required 0000000a", da); end
  endtask

  task automatic test_carry();
    logic [31:0] da, db;
    logic fa;
    wait_phase(0);
    do_write(BASE, 32'hFFFF_FFFF, fa);
    do_write(BASE + 32'h4, 32'd0, fa);
    wait_phase(0);
    do_read(BASE, da, fa, db);
    checks++; if (da !== 32'd0) begin errors++; $display("FAIL carry_lo: got %h required 0", da); end
    do_read(BASE + 32'h4, da, fa, db);
    checks++; if (da !== 32'd1) begin errors++; $display("FAIL carry_hi: got %h required 1", da); end
  endtask

  task automatic test_write_on_tick();
    logic [31:0] da, db;
    logic fa;
    wait_phase(0);
    do_write(BASE, 32'hFFFF_FFFF, fa);
    do_write(BASE + 32'h4, 32'd3, fa);
    wait_phase(99);
    do_write(BASE, 32'd5, fa);
    do_read(BASE, da, fa, db);
    checks++; if (da !== 32'd5) begin errors++; $display("FAIL wrl_tick_lo: got %h required 5", da); end
    do_read(BASE + 32'h4, da, fa, db);
    checks++; if (da !== 32'd4) begin errors++; $display("FAIL wrl_tick_hi: got %h required 4", da); end
    do_write(BASE, 32'd10, fa);
    wait_phase(99);
    do_write(BASE + 32'h4, 32'd8, fa);
    do_read(BASE, da, fa, db);
    checks++; if (da !== 32'd11) begin errors++; $display("FAIL wrh_tick_lo: got %h required b", da); end
    do_read(BASE + 32'h4, da, fa, db);
    checks++; if (da !== 32'd8) begin errors++; $display("FAIL wrh_tick_hi: got %h required 8", da); end
  endtask

  task automatic test_interrupt();
    logic fa;
    do_write(BASE + 32'h8, 32'd20, fa);
    do_write(BASE + 32'h4, 32'd0, fa);
    do_write(BASE, 32'd0, fa);          // mtime_b = 0 after this edge
    do_write(BASE + 32'hC, 32'd0, fa);  // mtimecmp = 20
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL int_early: got %b required 0", int_b); end
    repeat (19) @(posedge clk);
    #1;
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL int_before_20: got %b required 0", int_b); end
    @(posedge clk); #1;
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL int_rise: got %b required 1", int_b); end
    do_write(BASE + 32'hC, 32'd1, fa);
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL int_hold: got %b required 1", int_b); end
    @(posedge clk); #1;
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL int_fall: got %b required 0", int_b); end
  endtask

  task automatic test_shadow();
    logic [31:0] da, db;
    logic fa;
    wait_phase(0);
    do_write(BASE + 32'h4, 32'd7, fa);
    do_read(BASE, da, fa, db);
    do_write(BASE + 32'h4, 32'd9, fa);
    do_read(BASE + 32'h4, da, fa, db);
    checks++; if (da !== 32'd7) begin errors++; $display("FAIL shadow_old: got %h required 7", da); end
    do_read(BASE, da, fa, db);
    do_read(BASE + 32'h4, da, fa, db);
    checks++; if (da !== 32'd9) begin errors++; $display("FAIL shadow_new: got %h required 9", da); end
  endtask

  task automatic test_misaligned();
    logic [31:0] da, db;
    logic fa;
    do_read(BASE + 32'h2, da, fa, db);
    checks++; if (fa !== 1'b1) begin errors++; $display("FAIL misal_rd_fault: got %b required 1", fa); end
    checks++; if (da !== 32'd0) begin errors++; $display("FAIL misal_rd_data: got %h required 0", da); end
    do_write(BASE + 32'hA, 32'h0000_DEAD, fa);
    checks++; if (fa !== 1'b1) begin errors++; $display("FAIL misal_wr_fault: got %b required 1", fa); end
    do_write(BASE + 32'hE, 32'h0000_0055, fa);
    do_read(BASE + 32'h8, da, fa, db);
    checks++; if (da !== 32'd20) begin errors++; $display("FAIL misal_cmpl_kept: got %h required 14", da); end
    do_read(BASE + 32'hC, da, fa, db);
    checks++; if (da !== 32'd1) begin errors++; $display("FAIL misal_cmph_kept: got %h required 1", da); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] da, db;
    logic fa;
    do_read(BASE + 32'h10, da, fa, db);
    checks++; if (fa !== 1'b0) begin errors++; $display("FAIL oor_fault: got %b required 0", fa); end
    checks++; if (da !== 32'd0) begin errors++; $display("FAIL oor_data: got %h required 0", da); end
    do_read(BASE - 32'h4, da, fa, db);
    checks++; if (da !== 32'd0) begin errors++; $display("FAIL below_data: got %h required 0", da); end
    addr = BASE + 32'h8; rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    checks++; if (rd_data_a !== 32'd0) begin errors++; $display("FAIL no_rd_en_data: got %h required 0", rd_data_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_rw_same();
    logic [31:0] da, db;
    logic fa;
    logic [31:0] d;
    addr = BASE + 32'h8; wr_data = 32'd3; rd_en = 1'b1; wr_en = 1'b1;
    @(negedge clk);
    d = rd_data_a;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    $display("rdwr addr=%h wdata=%h rdata=%h", addr, 32'd3, d);
    checks++; if (d !== 32'd20) begin errors++; $display("FAIL rw_old_value: got %h required 14", d); end
    do_read(BASE + 32'h8, da, fa, db);
    checks++; if (da !== 32'd3) begin errors++; $display("FAIL rw_new_value: got %h required 3", da); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] da, db;
    logic fa;
    do_write(BASE + 32'hC, 32'd0, fa);   // mtimecmp_b = 3, mtime_b well above it
    @(posedge clk); #1;
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL pre_reset_int: got %b required 1", int_b); end
    rst_n = 1'b0; rd_en = 1'b1; addr = BASE + 32'h8;
    @(negedge clk);
    checks++; if (rd_data_b !== 32'd0) begin errors++; $display("FAIL in_reset_data: got %h required 0", rd_data_b); end
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL int_before_edge: got %b required 1", int_b); end
    @(posedge clk); #1;
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL reset_int_fall: got %b required 0", int_b); end
    checks++; if (int_a !== 1'b0) begin errors++; $display("FAIL reset_int_a: got %b required 0", int_a); end
    rd_en = 1'b0; rst_n = 1'b1;
    do_read(BASE, da, fa, db);
    checks++; if (da !== 32'd0) begin errors++; $display("FAIL rst_mtimel_a: got %h required 0", da); end
    checks++; if (db !== 32'd0) begin errors++; $display("FAIL rst_mtimel_b: got %h required 0", db); end
    do_read(BASE + 32'h4, da, fa, db);
    checks++; if (db !== 32'd0) begin errors++; $display("FAIL rst_mtimeh_b: got %h required 0", db); end
    do_read(BASE + 32'h8, da, fa, db);
    checks++; if (db !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmpl_b: got %h required ffffffff", db); end
    do_read(BASE + 32'hC, da, fa, db);
    checks++; if (db !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmph_b: got %h required ffffffff", db); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_carry();
    test_write_on_tick();
    test_interrupt();
    test_shadow();
    test_misaligned();
    test_out_of_range();
    test_rw_same();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
